// File: rtl/tdm_demux_1_8_pkg.sv
// Shared constants and state encoding for the 1:8 TDM demultiplexer.
package tdm_demux_1_8_pkg;

    localparam int unsigned NUM_CHANNELS = 8;
    localparam int unsigned SEL_WIDTH    = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage : tdm_demux_1_8_pkg

// File: rtl/tdm_slot_counter.sv
// Channel slot counter: clear to 0, load to 1 on a frame start, increment per accepted sample.
module tdm_slot_counter
    import tdm_demux_1_8_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 load_one,
    input  logic                 incr,
    output logic [SEL_WIDTH-1:0] count,
    output logic                 wrap_c
);

    // Last slot is being consumed this cycle; the counter wraps back to 0.
    assign wrap_c = incr & (count == SEL_WIDTH'(NUM_CHANNELS - 1));

    // Clear beats load, load beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load_one) begin
            count <= SEL_WIDTH'(1);
        end else if (incr) begin
            count <= count + SEL_WIDTH'(1);
        end
    end

endmodule : tdm_slot_counter

// File: rtl/tdm_demux_1_8.sv
// Receive end of an 8-slot TDM link: locks on frame sync and latches each sample into its channel.
module tdm_demux_1_8
    import tdm_demux_1_8_pkg::*;
(
    input  logic                    Clk_In,
    input  logic                    Reset_N_In,
    input  logic                    Enable_In,
    input  logic                    Serial_Data_In,
    input  logic                    Serial_Valid_In,
    input  logic                    Frame_Sync_In,
    input  logic                    Error_Clear_In,
    output logic [NUM_CHANNELS-1:0] Channel_Data_Out,
    output logic [NUM_CHANNELS-1:0] Channel_Update_Out,
    output logic [SEL_WIDTH-1:0]    Channel_Select_Out,
    output logic                    Frame_Done_Out,
    output logic                    Locked_Out,
    output logic                    Sync_Error_Out
);

    state_e                state;
    state_e                state_next;
    logic                  valid_c;
    logic                  sync_c;
    logic                  run_c;
    logic                  write_c;
    logic [SEL_WIDTH-1:0]  write_idx_c;
    logic                  incr_c;
    logic                  wrap_c;
    logic                  sync_err_c;

    // Qualified sample and marker for this cycle.
    assign valid_c = Enable_In & Serial_Valid_In;
    assign sync_c  = valid_c & Frame_Sync_In;
    assign run_c   = (state == RUN);

    // A marker always restarts at slot 0; otherwise only RUN accepts samples.
    assign write_c     = sync_c | (run_c & valid_c);
    assign write_idx_c = sync_c ? '0 : Channel_Select_Out;
    assign incr_c      = run_c & valid_c & ~Frame_Sync_In;
    assign sync_err_c  = run_c & sync_c & (Channel_Select_Out != '0);

    // Slot tracking; its count register is the published select.
    tdm_slot_counter u_slot_counter (
        .clk      (Clk_In),
        .rst_n    (Reset_N_In),
        .clear    (~Enable_In),
        .load_one (sync_c),
        .incr     (incr_c),
        .count    (Channel_Select_Out),
        .wrap_c   (wrap_c)
    );

    // State register.
    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: enable drop forces IDLE, a marker locks.
    always_comb begin
        state_next = state;
        if (!Enable_In) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (sync_c) state_next = RUN;
                RUN:     state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    // Channel data, strobes, lock and sticky error registers.
    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            Channel_Data_Out   <= '0;
            Channel_Update_Out <= '0;
            Frame_Done_Out     <= 1'b0;
            Locked_Out         <= 1'b0;
            Sync_Error_Out     <= 1'b0;
        end else begin
            if (write_c) begin
                Channel_Data_Out[write_idx_c] <= Serial_Data_In;
            end
            Channel_Update_Out <= write_c ? (NUM_CHANNELS'(1) << write_idx_c) : '0;
            Frame_Done_Out     <= wrap_c;
            Locked_Out         <= (state_next == RUN);
            if (sync_err_c) begin
                Sync_Error_Out <= 1'b1;
            end else if (Error_Clear_In) begin
                Sync_Error_Out <= 1'b0;
            end
        end
    end

endmodule : tdm_demux_1_8

// File: tb/tb_tdm_demux_1_8.sv
// Directed bench for tdm_demux_1_8: one sample per cycle, outputs sampled on the falling edge.
module tb_tdm_demux_1_8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       sdata;
    logic       svalid;
    logic       fsync;
    logic       eclr;
    logic [7:0] ch_data;
    logic [7:0] ch_upd;
    logic [2:0] ch_sel;
    logic       fdone;
    logic       locked;
    logic       serr;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [7:0] exp_data;
    logic [7:0] bits;

    tdm_demux_1_8 dut (
        .Clk_In             (clk),
        .Reset_N_In         (rst_n),
        .Enable_In          (en),
        .Serial_Data_In     (sdata),
        .Serial_Valid_In    (svalid),
        .Frame_Sync_In      (fsync),
        .Error_Clear_In     (eclr),
        .Channel_Data_Out   (ch_data),
        .Channel_Update_Out (ch_upd),
        .Channel_Select_Out (ch_sel),
        .Frame_Done_Out     (fdone),
        .Locked_Out         (locked),
        .Sync_Error_Out     (serr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input logic [7:0] d, input logic [7:0] u,
                           input logic [2:0] s, input logic fd, input logic lk, input logic er);
        chk({tag, ".data"},   32'(ch_data), 32'(d));
        chk({tag, ".update"}, 32'(ch_upd),  32'(u));
        chk({tag, ".select"}, 32'(ch_sel),  32'(s));
        chk({tag, ".done"},   32'(fdone),   32'(fd));
        chk({tag, ".locked"}, 32'(locked),  32'(lk));
        chk({tag, ".error"},  32'(serr),    32'(er));
    endtask

    // Drive one cycle of inputs at the falling edge; return at the next falling edge.
    task automatic step(input logic d, input logic v, input logic s,
                        input logic e = 1'b1, input logic c = 1'b0);
        sdata  = d;
        svalid = v;
        fsync  = s;
        en     = e;
        eclr   = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b1;
        sdata  = 1'b0;
        svalid = 1'b0;
        fsync  = 1'b0;
        eclr   = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("reset", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // 1: full frame 1,0,1,1,0,0,1,0 -> 8'h4D
        bits = 8'h4D;
        exp_data = 8'h00;
        step(bits[0], 1'b1, 1'b1);
        exp_data[0] = bits[0];
        chk_all("t1.slot0", exp_data, 8'h01, 3'd1, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k < 8; k++) begin
            step(bits[k], 1'b1, 1'b0);
            exp_data[k] = bits[k];
            chk_all($sformatf("t1.slot%0d", k), exp_data, 8'(1 << k), 3'((k + 1) % 8),
                    1'(k == 7), 1'b1, 1'b0);
        end
        chk("t1.final", 32'(ch_data), 32'h4D);

        // 2: samples before sync are discarded
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_all("t2.reset", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1'b0);
            chk_all("t2.nosync", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 1'b1);
        chk_all("t2.sync", 8'h01, 8'h01, 3'd1, 1'b0, 1'b1, 1'b0);

        // 4: gaps interleaved; frame completes after 8 valid samples -> 8'hE7
        bits = 8'hE7;
        exp_data = 8'h01;
        for (int k = 1; k < 8; k++) begin
            step(1'($urandom_range(0, 1)), 1'b0, 1'b1);
            chk_all($sformatf("t4.gap%0d", k), exp_data, 8'h00, 3'(k), 1'b0, 1'b1, 1'b0);
            step(bits[k], 1'b1, 1'b0);
            exp_data[k] = bits[k];
            chk_all($sformatf("t4.slot%0d", k), exp_data, 8'(1 << k), 3'((k + 1) % 8),
                    1'(k == 7), 1'b1, 1'b0);
        end
        chk("t4.final", 32'(ch_data), 32'hE7);

        // 3: misplaced sync at slot 5, then clear; set beats clear
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 1'b0);
            exp_data[k] = 1'b0;
            chk_all($sformatf("t3.slot%0d", k), exp_data, 8'(1 << k), 3'(k + 1),
                    1'b0, 1'b1, 1'b0);
        end
        step(1'b1, 1'b1, 1'b1);
        chk_all("t3.syncerr", 8'hE1, 8'h01, 3'd1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk_all("t3.clear", 8'hE1, 8'h02, 3'd2, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk_all("t3.setwins", 8'hE0, 8'h01, 3'd1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_all("t3.clear2", 8'hE0, 8'h00, 3'd1, 1'b0, 1'b1, 1'b0);

        // 5: enable drop at slot 3, re-enable needs a sync
        step(1'b1, 1'b1, 1'b0);
        chk_all("t5.slot1", 8'hE2, 8'h02, 3'd2, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk_all("t5.slot2", 8'hE6, 8'h04, 3'd3, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk_all("t5.disable", 8'hE6, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b1, 1'b0);
            chk_all("t5.nosync", 8'hE6, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 1'b1);
        chk_all("t5.sync", 8'hE7, 8'h01, 3'd1, 1'b0, 1'b1, 1'b0);

        // 6: async reset between clock edges mid-frame
        step(1'b0, 1'b1, 1'b0);
        chk_all("t6.slot1", 8'hE5, 8'h02, 3'd2, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk_all("t6.slot2", 8'hE1, 8'h04, 3'd3, 1'b0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_all("t6.async", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        chk_all("t6.nosync", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk_all("t6.sync", 8'h01, 8'h01, 3'd1, 1'b0, 1'b1, 1'b0);

        // Sticky error survives an enable drop
        step(1'b0, 1'b1, 1'b1);
        chk_all("t7.err", 8'h00, 8'h01, 3'd1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("t7.hold", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_tdm_demux_1_8

// File: doc/tdm_demux_1_8.md
Name: tdm_demux_1_8

Overview:
Sequential 1:8 time-division demultiplexer; the receive end of a TDM link whose transmit end is an 8:1 MUX driven by a scanning 3-bit select counter.
Locks onto a frame-sync marker, tracks the channel slot with its own counter, and latches each serial sample into the matching per-channel output register.
Raises per-channel update strobes, a frame-complete strobe and a sticky sync-error flag.
Sits between the serial link input and the per-channel consumers.

Parameters:
NUM_CHANNELS, 8, channel slots per frame; this revision supports only 8.
SEL_WIDTH, 3, slot counter width, equal to log2(NUM_CHANNELS).

Ports:
Clk_In  input  1  single clock, all logic on the rising edge
Reset_N_In  input  1  asynchronous active-low reset
Enable_In  input  1  block enable; low forces the IDLE state
Serial_Data_In  input  1  TDM sample stream
Serial_Valid_In  input  1  qualifies Serial_Data_In and Frame_Sync_In this cycle
Frame_Sync_In  input  1  with Serial_Valid_In high, marks the sample as slot 0
Error_Clear_In  input  1  synchronous clear of Sync_Error_Out
Channel_Data_Out  output  NUM_CHANNELS  registered per-channel data, bit k = channel k
Channel_Update_Out  output  NUM_CHANNELS  one-hot, 1-cycle pulse on the bit of the channel just written
Channel_Select_Out  output  SEL_WIDTH  slot number the next valid sample is written to
Frame_Done_Out  output  1  1-cycle pulse when slot 7 is written
Locked_Out  output  1  high while in RUN
Sync_Error_Out  output  1  sticky sync-error flag

Behaviour:
- Reset (async assert, sync release): state IDLE; Channel_Data_Out = 8'h00; Channel_Update_Out = 0; Channel_Select_Out = 0; Frame_Done_Out = 0; Locked_Out = 0; Sync_Error_Out = 0.
- Every output is a register; a write takes effect one cycle after the qualifying input edge.
- Valid sample means Enable_In & Serial_Valid_In.
- IDLE:
  - Valid samples without Frame_Sync_In are discarded; the slot counter stays 0.
  - A valid sample with Frame_Sync_In writes Channel_Data_Out[0], pulses Channel_Update_Out[0], sets the slot counter to 1 and moves to RUN.
- RUN:
  - Each valid sample writes Channel_Data_Out[slot], pulses Channel_Update_Out[slot] and increments the slot counter (7 wraps to 0).
  - Gaps (Serial_Valid_In low) hold the counter with no pulses.
  - Writing slot 7 pulses Frame_Done_Out in the same cycle as Channel_Update_Out[7].
- Sync marker at slot 0 in RUN: normal frame start, no error.
- Sync marker at slot != 0 in RUN:
  - Sync_Error_Out is set.
  - The sample is treated as slot 0: writes channel 0 and the counter becomes 1.
  - The partial frame does not pulse Frame_Done_Out.
- Slot 0 reached in RUN without a sync marker: accepted, no error (sync may be sparse).
- Enable_In low:
  - Next cycle: state IDLE, counter 0, Locked_Out 0, no pulses.
  - Channel_Data_Out and Sync_Error_Out hold.
- Error_Clear_In:
  - Clears Sync_Error_Out next cycle.
  - If a new error occurs in the same cycle, the set wins.
- Reset mid-frame: immediate return to reset values; the partial frame is lost.
- At most one channel is written per cycle; Channel_Update_Out is always one-hot or zero.

Decomposition:
- Shared package: state encoding (IDLE=1'b0, RUN=1'b1), NUM_CHANNELS and SEL_WIDTH constants.
- One natural sub-module: tdm_slot_counter, a 3-bit counter with load-to-1, increment-on-valid, clear and a wrap flag.
- Data registers and strobe decode stay in the top module.

Test Plan:
1. Reset, Enable=1, sync on the first valid sample, then the bit stream 1,0,1,1,0,0,1,0 across slots 0..7 -> Channel_Data_Out=8'h4D; Channel_Update_Out walks 01,02,04,...,80; Frame_Done_Out pulses once with bit 7; Locked_Out=1.
2. Valid samples before any sync -> Channel_Data_Out stays 00, no strobes, Locked_Out=0; the first sync starts writing at slot 0.
3. Sync asserted at slot 5 -> Sync_Error_Out=1, sample lands in channel 0, Channel_Select_Out=1, no Frame_Done_Out; Error_Clear_In pulse -> Sync_Error_Out=0 next cycle.
4. Serial_Valid_In toggled 1/0 during a frame -> slots advance only on valid cycles; Frame_Done_Out appears after exactly 8 valid samples.
5. Enable_In dropped at slot 3 -> IDLE, Channel_Data_Out holds, Channel_Select_Out=0; re-enable without sync -> no writes until the next sync.
6. Reset_N_In asserted asynchronously mid-frame, between clock edges -> all outputs 0 immediately; after release, a sync is required before any write.
